// File: rtl/page_stream_pkg.sv
// Shared types and constants for the page streamer: state encoding and
// the ASCII codes used by the optional hex-dump output format.
package page_stream_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_FETCH   = 4'd1;
  localparam state_t ST_WAIT    = 4'd2;
  localparam state_t ST_SEND    = 4'd3;
  localparam state_t ST_SEND_HI = 4'd4;
  localparam state_t ST_SEND_LO = 4'd5;
  localparam state_t ST_SEND_CR = 4'd6;
  localparam state_t ST_SEND_LF = 4'd7;
  localparam state_t ST_DONE    = 4'd8;

  localparam logic [7:0] CHR_CR         = 8'h0D;
  localparam logic [7:0] CHR_LF         = 8'h0A;
  localparam logic [7:0] CHR_0          = 8'h30;
  localparam logic [7:0] CHR_A_MINUS_10 = 8'h37;

endpackage

// File: rtl/page_stream_hex_enc.sv
// Nibble to uppercase ASCII hex character ('0'-'9', 'A'-'F').
module page_stream_hex_enc
  import page_stream_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  // Digits offset from '0', letters offset so that 10 maps to 'A'
  always_comb begin
    chr = (nib < 4'd10) ? (CHR_0 + {4'd0, nib}) : (CHR_A_MINUS_10 + {4'd0, nib});
  end

endmodule

// File: rtl/page_streamer.sv
// Page read-out sequencer: walks one page of a byte buffer and forwards
// each byte to a valid/ready TX sink. Define HEX_DUMP_EN to emit each byte
// as two ASCII hex characters with a CR/LF after every page.
module page_streamer
  import page_stream_pkg::*;
#(
  parameter int PAGE_BYTES     = 16,
  parameter int NUM_PAGES      = 4,
  parameter int BUF_ADDR_WIDTH = 15,
  parameter int DATA_WIDTH     = 8,
  localparam int PG_W  = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int IDX_W = $clog2(PAGE_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PG_W-1:0]           page_sel,
  input  logic                      continuous,
  input  logic                      abort,
  output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
  output logic                      buf_rd_en,
  input  logic [DATA_WIDTH-1:0]     buf_data,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          byte_idx
);

  localparam logic [PG_W-1:0]  LAST_PG  = PG_W'(NUM_PAGES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_BYTES - 1);

  state_t          state;
  logic [PG_W-1:0] page;
  logic            hs;
  logic            last_byte;

  // Page size is a power of two, so page*PAGE_BYTES+idx is a concatenation
  assign buf_addr  = BUF_ADDR_WIDTH'({page, byte_idx});
  assign buf_rd_en = (state == ST_FETCH);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign hs        = tx_valid & tx_ready;
  assign last_byte = (byte_idx == LAST_IDX);

`ifdef HEX_DUMP_EN
  logic [3:0] lo_nib;
  logic [7:0] hi_chr;
  logic [7:0] lo_chr;

  page_stream_hex_enc u_enc_hi (.nib(buf_data[7:4]), .chr(hi_chr));
  page_stream_hex_enc u_enc_lo (.nib(lo_nib),        .chr(lo_chr));
`endif

  // Sequencer: fetch, wait for read data, present to TX, repeat per byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      page     <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
`ifdef HEX_DUMP_EN
      lo_nib   <= '0;
`endif
    end else if (abort && state != ST_IDLE) begin
      // A handshake on this same edge still counts; nothing to undo
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      byte_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            page     <= ({1'b0, page_sel} >= (PG_W + 1)'(NUM_PAGES)) ? LAST_PG : page_sel;
            byte_idx <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_WAIT;
`ifdef HEX_DUMP_EN
        ST_WAIT: begin
          lo_nib   <= buf_data[3:0];
          tx_data  <= DATA_WIDTH'(hi_chr);
          tx_valid <= 1'b1;
          state    <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (hs) begin
            tx_data <= DATA_WIDTH'(lo_chr);
            state   <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (hs) begin
            if (last_byte) begin
              tx_data <= DATA_WIDTH'(CHR_CR);
              state   <= ST_SEND_CR;
            end else begin
              tx_valid <= 1'b0;
              byte_idx <= byte_idx + 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_SEND_CR: begin
          if (hs) begin
            tx_data <= DATA_WIDTH'(CHR_LF);
            state   <= ST_SEND_LF;
          end
        end
        ST_SEND_LF: begin
          if (hs) begin
            tx_valid <= 1'b0;
            byte_idx <= '0;
            state    <= ST_DONE;
          end
        end
`else
        ST_WAIT: begin
          tx_data  <= buf_data;
          tx_valid <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            tx_valid <= 1'b0;
            if (last_byte) begin
              byte_idx <= '0;
              state    <= ST_DONE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
`endif
        ST_DONE: state <= continuous ? ST_FETCH : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_streamer.sv
// Self-checking bench for page_streamer: directed scenarios plus a
// randomized phase, all checked against a queue-based stream model.
module tb_page_streamer;

  localparam int PB = 16;
  localparam int NP = 4;
  localparam int AW = 15;
  localparam int DW = 8;
`ifdef HEX_DUMP_EN
  localparam int CPB = 2;  // characters per buffer byte
  localparam int TRL = 2;  // trailing CR LF per page
`else
  localparam int CPB = 1;
  localparam int TRL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start, continuous, abort, tx_ready;
  logic [1:0]    page_sel;
  logic [AW-1:0] buf_addr;
  logic          buf_rd_en;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid, busy, done;
  logic [3:0]    byte_idx;

  page_streamer #(.PAGE_BYTES(PB), .NUM_PAGES(NP), .BUF_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .page_sel(page_sel), .continuous(continuous),
    .abort(abort), .buf_addr(buf_addr), .buf_rd_en(buf_rd_en), .buf_data(buf_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  // Buffer model: synchronous read, data one cycle after the strobe
  logic [7:0] mem [0:63];
  always @(posedge clk) if (buf_rd_en) buf_data <= mem[buf_addr[5:0]];

  // Observation: everything the DUT hands over, recorded at the falling edge
  logic [7:0] got_q [$];
  int         addr_q [$];
  logic [7:0] exp_q [$];
  int         done_cnt, rd_cnt, cyc, last_hs_cyc, done_cyc;
  int         n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_hs_cyc = cyc;
      end
      if (buf_rd_en) begin
        addr_q.push_back(int'(buf_addr));
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
    rd_cnt   = 0;
  endtask

  // Reference stream: the selected page (clamped) rendered byte by byte
  task automatic build_exp(input int sel, input int passes);
    string hexs = "0123456789ABCDEF";
    int pg;
    pg = (sel >= NP) ? NP - 1 : sel;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < PB; i++) begin
        if (CPB == 2) begin
          exp_q.push_back(hexs[mem[pg*PB+i] / 16]);
          exp_q.push_back(hexs[mem[pg*PB+i] % 16]);
        end else begin
          exp_q.push_back(mem[pg*PB+i]);
        end
      end
      if (TRL == 2) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic check_addr(input string tag, input int pg, input int passes);
    chk({tag, "_naddr"}, addr_q.size(), PB * passes);
    for (int i = 0; i < addr_q.size() && i < PB * passes; i++)
      chk($sformatf("%s_addr[%0d]", tag, i), addr_q[i], pg * PB + (i % PB));
  endtask

  task automatic do_start(input int sel);
    page_sel = sel[1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    for (int k = 0; k < 3000 && busy; k++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk({tag, "_timeout"}, busy, 1'b0);
    tx_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 0; page_sel = 0; continuous = 0; abort = 0; tx_ready = 1;
    cyc = 0; last_hs_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    clear_mon();
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", buf_rd_en, 0);
    chk("rst_addr", buf_addr, 0);
    chk("rst_idx", byte_idx, 0);
    chk("rst_data", tx_data, 0);
    rst = 1'b0;
    tick();

    // Plain page 2 with first-byte latency
    clear_mon();
    build_exp(2, 1);
    do_start(2);
    chk("lat_rden", buf_rd_en, 1);
    chk("lat_addr", buf_addr, 32);
    chk("lat_busy", busy, 1);
    tick();
    chk("lat_wait_valid", tx_valid, 0);
    tick();
    chk("lat_valid", tx_valid, 1);
    chk("lat_data", tx_data, exp_q[0]);
    wait_idle("p2", 0);
    check_stream("p2");
    check_addr("p2", 2, 1);
    chk("p2_done_cnt", done_cnt, 1);
    chk("p2_done_after_last", (done_cyc > last_hs_cyc && done_cyc <= last_hs_cyc + 3), 1);

    // Stall at byte 5
    clear_mon();
    build_exp(2, 1);
    do_start(2);
    for (int k = 0; k < 200 && !(tx_valid && byte_idx == 4'd5); k++) tick();
    tx_ready = 1'b0;
    begin
      int rd0;
      rd0 = rd_cnt;
      for (int k = 0; k < 10; k++) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, exp_q[5*CPB]);
        tick();
      end
      chk("stall_no_rd", rd_cnt, rd0);
    end
    tx_ready = 1'b1;
    wait_idle("stall", 0);
    check_stream("stall");
    chk("stall_rd_total", rd_cnt, PB);

    // Continuous page 1: two passes, drop continuous during the second
    clear_mon();
    build_exp(1, 2);
    continuous = 1'b1;
    do_start(1);
    for (int k = 0; k < 500 && !done; k++) tick();
    chk("cont_first_done", done, 1);
    tick();
    continuous = 1'b0;
    wait_idle("cont", 0);
    check_stream("cont");
    check_addr("cont", 1, 2);
    chk("cont_done_cnt", done_cnt, 2);

    // Abort in WAIT of byte 7, then a fresh start on page 0
    clear_mon();
    build_exp(2, 1);
    do_start(2);
    for (int k = 0; k < 200 && !(buf_rd_en && byte_idx == 4'd7); k++) tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", tx_valid, 0);
    chk("abort_idx", byte_idx, 0);
    tick(); tick(); tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_len", got_q.size(), 7 * CPB);
    for (int i = 0; i < got_q.size() && i < 7 * CPB; i++)
      chk($sformatf("abort[%0d]", i), got_q[i], exp_q[i]);
    clear_mon();
    build_exp(0, 1);
    do_start(0);
    wait_idle("after_abort", 0);
    check_stream("after_abort");
    chk("after_abort_done", done_cnt, 1);

    // Start while busy ignored; select 7 lands on page 3
    clear_mon();
    build_exp(3, 1);
    do_start(7);
    repeat (8) tick();
    do_start(0);
    wait_idle("busy_start", 0);
    check_stream("busy_start");
    check_addr("busy_start", 3, 1);
    chk("busy_start_done", done_cnt, 1);

`ifdef HEX_DUMP_EN
    // Hex rendering of a known byte
    mem[16] = 8'hA5;
    clear_mon();
    do_start(1);
    wait_idle("hex", 0);
    chk("hex_c0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h41);
    chk("hex_c1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h35);
    chk("hex_cr", got_q.size() > 1 ? got_q[got_q.size()-2] : 8'hxx, 8'h0D);
    chk("hex_lf", got_q.size() > 0 ? got_q[got_q.size()-1] : 8'hxx, 8'h0A);
    chk("hex_done", done_cnt, 1);
`endif

    // Randomized contents, page and back-pressure
    for (int it = 0; it < 6; it++) begin
      int sel;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      sel = $urandom_range(0, 3);
      clear_mon();
      build_exp(sel, 1);
      do_start(sel);
      wait_idle($sformatf("rnd%0d", it), 1);
      check_stream($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_done", it), done_cnt, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
